// File: rtl/dmem_pkg.sv
// Shared encodings for the data memory: access sizes, FSM states and the
// wait-state counter width, plus the alignment/legality rule.
package dmem_pkg;

    typedef enum logic [1:0] {
        SZ_BYTE = 2'b00,
        SZ_HALF = 2'b01,
        SZ_WORD = 2'b10,
        SZ_RSVD = 2'b11
    } size_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_WAIT = 2'b01,
        ST_RESP = 2'b10
    } state_e;

    // WAIT_STATES tops out at 15, so a 4-bit down-counter is enough.
    localparam int WS_CNT_W = 4;

    function automatic logic access_fault(input logic [1:0] size, input logic [1:0] offset);
        case (size_e'(size))
            SZ_BYTE: access_fault = 1'b0;
            SZ_HALF: access_fault = offset[0];
            SZ_WORD: access_fault = (offset != 2'b00);
            default: access_fault = 1'b1;
        endcase
    endfunction

endpackage

// File: rtl/dmem_align.sv
// Combinational byte-lane steering between a 32-bit storage word and the
// right-justified bus data, with endianness ordering and sign/zero extension.
module dmem_align
    import dmem_pkg::*;
#(
    parameter bit BIG_ENDIAN = 1'b1
) (
    input  logic [1:0]  i_size,
    input  logic        i_sign_ext,
    input  logic [1:0]  i_offset,
    input  logic [31:0] i_wdata,
    input  logic [31:0] i_rword,
    output logic [31:0] o_wword,
    output logic [3:0]  o_byte_en,
    output logic [31:0] o_rdata
);

    // Lane k holds the byte at word-base address + k.
    logic [7:0]  w_lane [4];
    logic [7:0]  w_byte;
    logic [15:0] w_half;
    logic [31:0] w_word;
    logic [1:0]  w_half_lo;
    logic [1:0]  w_half_hi;

    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_lane
            assign w_lane[gi] = i_rword[8*gi +: 8];
        end
    endgenerate

    assign w_half_lo = {i_offset[1], 1'b0};
    assign w_half_hi = {i_offset[1], 1'b1};

    always_comb begin
        w_byte = w_lane[i_offset];
        w_half = BIG_ENDIAN ? {w_lane[w_half_lo], w_lane[w_half_hi]}
                            : {w_lane[w_half_hi], w_lane[w_half_lo]};
        w_word = BIG_ENDIAN ? {w_lane[0], w_lane[1], w_lane[2], w_lane[3]} : i_rword;
        case (size_e'(i_size))
            SZ_BYTE: o_rdata = {{24{i_sign_ext & w_byte[7]}}, w_byte};
            SZ_HALF: o_rdata = {{16{i_sign_ext & w_half[15]}}, w_half};
            SZ_WORD: o_rdata = w_word;
            default: o_rdata = '0;
        endcase
    end

    // Write data is replicated across lanes; the byte enables pick the target.
    always_comb begin
        case (size_e'(i_size))
            SZ_BYTE: begin
                o_wword   = {4{i_wdata[7:0]}};
                o_byte_en = 4'b0001 << i_offset;
            end
            SZ_HALF: begin
                o_wword   = BIG_ENDIAN ? {2{i_wdata[7:0], i_wdata[15:8]}} : {2{i_wdata[15:0]}};
                o_byte_en = i_offset[1] ? 4'b1100 : 4'b0011;
            end
            SZ_WORD: begin
                o_wword   = BIG_ENDIAN ? {i_wdata[7:0], i_wdata[15:8], i_wdata[23:16], i_wdata[31:24]}
                                       : i_wdata;
                o_byte_en = 4'b1111;
            end
            default: begin
                o_wword   = '0;
                o_byte_en = 4'b0000;
            end
        endcase
    end

endmodule

// File: rtl/data_memory_sync.sv
// Byte-addressed data memory with configurable wait states, endianness and
// alignment faults; a three-state FSM sequences each access.
module data_memory_sync
    import dmem_pkg::*;
#(
    parameter int ADDR_W      = 8,
    parameter int WAIT_STATES = 1,
    parameter bit BIG_ENDIAN  = 1'b1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req,
    input  logic              we,
    input  logic [1:0]        size,
    input  logic              sign_ext,
    input  logic [ADDR_W-1:0] addr,
    input  logic [31:0]       wdata,
    output logic [31:0]       rdata,
    output logic              ack,
    output logic              fault
);

    localparam int DEPTH = 2 ** (ADDR_W - 2);

    logic [31:0] r_mem [0:DEPTH-1];

    state_e              r_state;
    logic [WS_CNT_W-1:0] r_cnt;
    logic                r_we;
    logic [1:0]          r_size;
    logic                r_sext;
    logic [ADDR_W-1:0]   r_addr;
    logic [31:0]         r_wdata;
    logic [31:0]         r_rdata;
    logic                r_ack;
    logic                r_fault;

    logic                w_idle;
    logic                w_bad;
    logic                w_commit;
    logic                w_sel_we;
    logic [1:0]          w_sel_size;
    logic                w_sel_sext;
    logic [ADDR_W-1:0]   w_sel_addr;
    logic [31:0]         w_sel_wdata;
    logic [31:0]         w_rword;
    logic [31:0]         w_wword;
    logic [3:0]          w_byte_en;
    logic [31:0]         w_rd_data;

    assign w_idle = (r_state == ST_IDLE);
    assign w_bad  = access_fault(size, addr[1:0]);

    // With no wait states the access commits on the accepting edge itself,
    // so the live inputs are used while still in IDLE.
    assign w_sel_we    = w_idle ? we       : r_we;
    assign w_sel_size  = w_idle ? size     : r_size;
    assign w_sel_sext  = w_idle ? sign_ext : r_sext;
    assign w_sel_addr  = w_idle ? addr     : r_addr;
    assign w_sel_wdata = w_idle ? wdata    : r_wdata;

    assign w_commit = rst_n &&
                      ((w_idle && req && !w_bad && (WAIT_STATES == 0)) ||
                       (r_state == ST_WAIT && r_cnt == '0));

    assign w_rword = r_mem[w_sel_addr[ADDR_W-1:2]];

    dmem_align #(
        .BIG_ENDIAN (BIG_ENDIAN)
    ) u_align (
        .i_size     (w_sel_size),
        .i_sign_ext (w_sel_sext),
        .i_offset   (w_sel_addr[1:0]),
        .i_wdata    (w_sel_wdata),
        .i_rword    (w_rword),
        .o_wword    (w_wword),
        .o_byte_en  (w_byte_en),
        .o_rdata    (w_rd_data)
    );

    always_ff @(posedge clk) begin
        if (w_commit && w_sel_we) begin
            for (int i = 0; i < 4; i++) begin
                if (w_byte_en[i]) begin
                    r_mem[w_sel_addr[ADDR_W-1:2]][8*i +: 8] <= w_wword[8*i +: 8];
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
            r_cnt   <= '0;
            r_we    <= 1'b0;
            r_size  <= '0;
            r_sext  <= 1'b0;
            r_addr  <= '0;
            r_wdata <= '0;
            r_rdata <= '0;
            r_ack   <= 1'b0;
            r_fault <= 1'b0;
        end else begin
            r_ack   <= 1'b0;
            r_fault <= 1'b0;
            if (w_commit && !w_sel_we) begin
                r_rdata <= w_rd_data;
            end
            case (r_state)
                ST_IDLE: begin
                    if (req) begin
                        r_we    <= we;
                        r_size  <= size;
                        r_sext  <= sign_ext;
                        r_addr  <= addr;
                        r_wdata <= wdata;
                        if (w_bad) begin
                            r_state <= ST_RESP;
                            r_ack   <= 1'b1;
                            r_fault <= 1'b1;
                        end else if (WAIT_STATES == 0) begin
                            r_state <= ST_RESP;
                            r_ack   <= 1'b1;
                        end else begin
                            r_state <= ST_WAIT;
                            r_cnt   <= WS_CNT_W'(WAIT_STATES - 1);
                        end
                    end
                end
                ST_WAIT: begin
                    if (r_cnt == '0) begin
                        r_state <= ST_RESP;
                        r_ack   <= 1'b1;
                    end else begin
                        r_cnt <= r_cnt - 1'b1;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign rdata = r_rdata;
    assign ack   = r_ack;
    assign fault = r_fault;

endmodule

// File: tb/tb_data_memory_sync.sv
// Directed bench: a two-wait-state big-endian instance driven from a vector
// table, plus a zero-wait-state instance for back-to-back throughput.
module tb_data_memory_sync;

    logic        clk;
    logic        rst_n;

    logic        req, we, sign_ext;
    logic [1:0]  size;
    logic [7:0]  addr;
    logic [31:0] wdata, rdata;
    logic        ack, fault;

    logic        req0, we0, sign_ext0;
    logic [1:0]  size0;
    logic [7:0]  addr0;
    logic [31:0] wdata0, rdata0;
    logic        ack0, fault0;

    int checks = 0;
    int errors = 0;

    data_memory_sync #(.ADDR_W(8), .WAIT_STATES(2), .BIG_ENDIAN(1'b1)) dut (
        .clk(clk), .rst_n(rst_n), .req(req), .we(we), .size(size),
        .sign_ext(sign_ext), .addr(addr), .wdata(wdata),
        .rdata(rdata), .ack(ack), .fault(fault)
    );

    data_memory_sync #(.ADDR_W(8), .WAIT_STATES(0), .BIG_ENDIAN(1'b1)) dut0 (
        .clk(clk), .rst_n(rst_n), .req(req0), .we(we0), .size(size0),
        .sign_ext(sign_ext0), .addr(addr0), .wdata(wdata0),
        .rdata(rdata0), .ack(ack0), .fault(fault0)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        we;
        logic [1:0]  size;
        logic        sext;
        logic [7:0]  addr;
        logic [31:0] wdata;
        logic [31:0] exp_rdata;
        logic        exp_fault;
        int          exp_lat;
    } vec_t;

    vec_t vecs[$];

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h expected %h", name, got, exp);
        end
    endtask

    // One access on the WS=2 instance; inputs are scrambled right after the
    // accepting edge to show the captured copy is what gets used.
    task automatic access(input logic iwe, input logic [1:0] isz, input logic isx,
                          input logic [7:0] iad, input logic [31:0] iwd,
                          output logic [31:0] ord, output logic oflt, output int olat,
                          output logic opulse);
        @(negedge clk);
        req = 1'b1; we = iwe; size = isz; sign_ext = isx; addr = iad; wdata = iwd;
        @(posedge clk); #1;
        req = 1'b0; we = ~iwe; size = ~isz; sign_ext = ~isx; addr = ~iad; wdata = 32'hDEADBEEF;
        olat = 1;
        while (!ack && olat < 20) begin
            @(posedge clk); #1;
            olat++;
        end
        ord  = rdata;
        oflt = fault;
        @(posedge clk); #1;
        opulse = ack;
    endtask

    initial begin
        logic [31:0] rd;
        logic        flt, pulse;
        int          lat;

        rst_n = 1'b0;
        req = 0; we = 0; size = 0; sign_ext = 0; addr = 0; wdata = 0;
        req0 = 0; we0 = 0; size0 = 0; sign_ext0 = 0; addr0 = 0; wdata0 = 0;
        #1;
        chk("reset_rdata", rdata, 32'h0);
        chk("reset_ack", {31'b0, ack}, 32'h0);
        chk("reset_fault", {31'b0, fault}, 32'h0);
        repeat (2) @(posedge clk);
        @(negedge clk) rst_n = 1'b1;

        //               we    size  sx   addr   wdata          exp_rdata      flt lat
        vecs.push_back('{1'b1, 2'b10, 1'b0, 8'h08, 32'hABCDEF01, 32'h00000000, 1'b0, 3});
        vecs.push_back('{1'b0, 2'b00, 1'b1, 8'h08, 32'h0,        32'hFFFFFFAB, 1'b0, 3});
        vecs.push_back('{1'b1, 2'b10, 1'b0, 8'h00, 32'h11223344, 32'hFFFFFFAB, 1'b0, 3});
        vecs.push_back('{1'b1, 2'b00, 1'b0, 8'h00, 32'h000000A6, 32'hFFFFFFAB, 1'b0, 3});
        vecs.push_back('{1'b1, 2'b00, 1'b0, 8'h02, 32'h000000DD, 32'hFFFFFFAB, 1'b0, 3});
        vecs.push_back('{1'b0, 2'b10, 1'b1, 8'h00, 32'h0,        32'hA622DD44, 1'b0, 3});
        vecs.push_back('{1'b1, 2'b10, 1'b0, 8'h04, 32'hCAFEF00D, 32'hA622DD44, 1'b0, 3});
        vecs.push_back('{1'b1, 2'b01, 1'b0, 8'h04, 32'h00008001, 32'hA622DD44, 1'b0, 3});
        vecs.push_back('{1'b0, 2'b01, 1'b0, 8'h04, 32'h0,        32'h00008001, 1'b0, 3});
        vecs.push_back('{1'b0, 2'b01, 1'b1, 8'h04, 32'h0,        32'hFFFF8001, 1'b0, 3});
        vecs.push_back('{1'b1, 2'b10, 1'b0, 8'h06, 32'h55667788, 32'hFFFF8001, 1'b1, 1});
        vecs.push_back('{1'b1, 2'b11, 1'b0, 8'h00, 32'h000000EE, 32'hFFFF8001, 1'b1, 1});
        vecs.push_back('{1'b0, 2'b11, 1'b0, 8'h04, 32'h0,        32'hFFFF8001, 1'b1, 1});
        vecs.push_back('{1'b0, 2'b01, 1'b0, 8'h05, 32'h0,        32'hFFFF8001, 1'b1, 1});
        vecs.push_back('{1'b0, 2'b10, 1'b0, 8'h02, 32'h0,        32'hFFFF8001, 1'b1, 1});
        vecs.push_back('{1'b0, 2'b10, 1'b0, 8'h04, 32'h0,        32'h8001F00D, 1'b0, 3});
        vecs.push_back('{1'b0, 2'b10, 1'b0, 8'h08, 32'h0,        32'hABCDEF01, 1'b0, 3});
        vecs.push_back('{1'b0, 2'b10, 1'b0, 8'h00, 32'h0,        32'hA622DD44, 1'b0, 3});
        vecs.push_back('{1'b0, 2'b00, 1'b0, 8'h09, 32'h0,        32'h000000CD, 1'b0, 3});
        vecs.push_back('{1'b0, 2'b01, 1'b1, 8'h0A, 32'h0,        32'hFFFFEF01, 1'b0, 3});
        vecs.push_back('{1'b0, 2'b00, 1'b1, 8'h0B, 32'h0,        32'h00000001, 1'b0, 3});
        vecs.push_back('{1'b0, 2'b00, 1'b0, 8'h00, 32'h0,        32'h000000A6, 1'b0, 3});
        vecs.push_back('{1'b1, 2'b01, 1'b0, 8'h06, 32'hFFFF1234, 32'h000000A6, 1'b0, 3});
        vecs.push_back('{1'b0, 2'b10, 1'b0, 8'h04, 32'h0,        32'h80011234, 1'b0, 3});
        vecs.push_back('{1'b1, 2'b10, 1'b0, 8'h0C, 32'h01020304, 32'h80011234, 1'b0, 3});

        foreach (vecs[i]) begin
            access(vecs[i].we, vecs[i].size, vecs[i].sext, vecs[i].addr, vecs[i].wdata,
                   rd, flt, lat, pulse);
            $display("vec%0d we=%0b size=%0b addr=%h wdata=%h -> rdata=%h fault=%0b lat=%0d",
                     i, vecs[i].we, vecs[i].size, vecs[i].addr, vecs[i].wdata, rd, flt, lat);
            chk($sformatf("vec%0d_rdata", i), rd, vecs[i].exp_rdata);
            chk($sformatf("vec%0d_fault", i), {31'b0, flt}, {31'b0, vecs[i].exp_fault});
            chk($sformatf("vec%0d_latency", i), 32'(lat), 32'(vecs[i].exp_lat));
            chk($sformatf("vec%0d_ack_single", i), {31'b0, pulse}, 32'h0);
        end

        // Reset during WAIT aborts a word write to 12.
        @(negedge clk);
        req = 1'b1; we = 1'b1; size = 2'b10; sign_ext = 1'b0; addr = 8'h0C; wdata = 32'hFFFFFFFF;
        @(posedge clk); #1;
        req = 1'b0;
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("abort_rdata_cleared", rdata, 32'h0);
        chk("abort_ack_low", {31'b0, ack}, 32'h0);
        @(posedge clk);
        @(negedge clk) rst_n = 1'b1;
        begin
            logic seen;
            seen = 1'b0;
            for (int c = 0; c < 6; c++) begin
                @(posedge clk); #1;
                if (ack) seen = 1'b1;
            end
            chk("abort_no_ack", {31'b0, seen}, 32'h0);
        end
        $display("abort: write to 0c aborted by reset during WAIT");
        access(1'b0, 2'b10, 1'b0, 8'h0C, 32'h0, rd, flt, lat, pulse);
        $display("abort_readback addr=0c -> rdata=%h lat=%0d", rd, lat);
        chk("abort_readback", rd, 32'h01020304);

        // Zero wait states with req held high: ack on every second cycle.
        @(negedge clk);
        req0 = 1'b1; we0 = 1'b1; size0 = 2'b10; addr0 = 8'h10; wdata0 = 32'h12345678;
        for (int c = 0; c < 8; c++) begin
            @(posedge clk); #1;
            $display("b2b cycle %0d ack=%0b", c, ack0);
            chk($sformatf("b2b_ack_c%0d", c), {31'b0, ack0}, (c % 2 == 0) ? 32'h1 : 32'h0);
        end
        @(negedge clk);
        req0 = 1'b1; we0 = 1'b0; size0 = 2'b10; addr0 = 8'h10;
        @(posedge clk); #1;
        req0 = 1'b0;
        $display("ws0 read addr=10 -> rdata=%h ack=%0b", rdata0, ack0);
        chk("ws0_read_ack", {31'b0, ack0}, 32'h1);
        chk("ws0_read_rdata", rdata0, 32'h12345678);
        chk("ws0_read_fault", {31'b0, fault0}, 32'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/data_memory_sync.md
DATA_MEMORY_SYNC -- requirements
Module: data_memory_sync

Interface
REQ-001 SHALL provide parameter ADDR_W, default 8, byte-address width; storage is 2**ADDR_W bytes.
REQ-002 SHALL provide parameter WAIT_STATES, default 1, range 0..15, extra cycles inserted before each access commits.
REQ-003 SHALL provide parameter BIG_ENDIAN, default 1; 1 = most significant byte at lowest address, 0 = little-endian.
REQ-004 SHALL have one clock; reset is asynchronous and active-low.
REQ-005 clk  in  1  rising-edge clock.
REQ-006 rst_n  in  1  asynchronous active-low reset.
REQ-007 req  in  1  access request, sampled only in IDLE.
REQ-008 we  in  1  1 = write, 0 = read.
REQ-009 size  in  2  00 byte, 01 halfword, 10 word, 11 reserved.
REQ-010 sign_ext  in  1  reads only; 1 = sign-extend byte/halfword, 0 = zero-extend.
REQ-011 addr  in  ADDR_W  byte address.
REQ-012 wdata  in  32  write data, right-justified for byte/halfword.
REQ-013 rdata  out  32  read data, valid in the ack cycle.
REQ-014 ack  out  1  one-cycle completion pulse.
REQ-015 fault  out  1  one-cycle pulse coincident with ack on a rejected access.

Function
REQ-016 SHALL implement FSM IDLE -> WAIT -> RESP -> IDLE; WAIT is skipped when WAIT_STATES = 0.
REQ-017 In IDLE with req = 1, SHALL register addr, we, size, sign_ext and wdata; inputs are ignored afterwards until IDLE is re-entered.
REQ-018 In WAIT, SHALL count down WAIT_STATES cycles, then enter RESP.
REQ-019 SHALL commit writes and capture read data on the clock edge entering RESP.
REQ-020 SHALL assert ack for exactly the RESP cycle, WAIT_STATES+1 cycles after the accepting edge.
REQ-021 Throughput SHALL be one access per WAIT_STATES+2 cycles; req held high through RESP starts the next access in the following IDLE cycle.
REQ-022 SHALL lay out the bytes of a word at addr..addr+3 per BIG_ENDIAN, and the bytes of a halfword at addr..addr+1 per BIG_ENDIAN.
REQ-023 Byte and halfword writes SHALL modify only their addressed bytes.
REQ-024 Byte and halfword reads SHALL right-justify data and extend it per sign_ext; sign_ext SHALL be ignored for word reads.
REQ-025 SHALL fault when size = 11, or when a halfword has addr[0] != 0, or when a word has addr[1:0] != 0.
REQ-026 On a fault, SHALL go directly to RESP, pulse ack and fault together, perform no memory write, and leave rdata unchanged.
REQ-027 rdata SHALL hold its last read value through writes, faults and idle cycles.
REQ-028 Address arithmetic SHALL NOT wrap; aligned accesses never cross the top of memory.

Reset
REQ-029 rst_n low SHALL force IDLE, ack = 0, fault = 0, rdata = 0 and wait counter = 0 immediately.
REQ-030 Memory contents SHALL NOT be reset; contents after power-up are undefined.
REQ-031 Reset asserted during WAIT SHALL abort the access; no write commits and no ack is produced.

Structure
REQ-032 SHALL place the size encodings, FSM state encoding and the WAIT_STATES counter width in package dmem_pkg.
REQ-033 SHALL place byte-lane steering, endianness ordering and sign/zero extension in combinational sub-module dmem_align; the FSM and storage stay in data_memory_sync.

Verification
REQ-034 Run with WAIT_STATES = 2 and BIG_ENDIAN = 1: word write 0xABCDEF01 at addr 8, then byte read of addr 8 with sign_ext = 1 -> rdata 0xFFFFFFAB, and ack 3 cycles after acceptance.
REQ-035 Word write 0x11223344 at addr 0, byte write 0xA6 at addr 0, byte write 0xDD at addr 2, then word read of addr 0 -> 0xA622DD44.
REQ-036 Halfword write 0x8001 at addr 4, halfword read of addr 4 with sign_ext = 0 -> 0x00008001; with sign_ext = 1 -> 0xFFFF8001.
REQ-037 Word write at addr 6 or any access with size = 11 -> ack and fault pulse together, memory unchanged, and rdata keeps its prior value.
REQ-038 Word write at addr 12 with rst_n pulsed low during WAIT -> no ack; a later read of addr 12 returns the pre-write contents.
REQ-039 Run with WAIT_STATES = 0 and req held high: back-to-back accesses -> ack every second cycle.
